// File: rtl/sgd_x_updated_rd_out_pkg.sv
// Shared constants and types for the x_updated read-out engine.
//   NUM_BITS_PER_BANK : 32-bit model lanes per x_updated bank word
//   BIT_WIDTH_OF_BANK : log2(NUM_BITS_PER_BANK)
//   X_BIT_DEPTH       : x_updated BRAM address width
//   rd_out_state_t    : sweep FSM states
package sgd_x_updated_rd_out_pkg;

  localparam int unsigned NUM_BITS_PER_BANK = 8;
  localparam int unsigned BIT_WIDTH_OF_BANK = 3;
  localparam int unsigned X_BIT_DEPTH       = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } rd_out_state_t;

endpackage

// File: rtl/sgd_rd_out_fifo.sv
// First-word-fall-through buffer between the BRAM return path and the
// writeback interface.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write one word (caller guarantees space)
//   pop      : release the head word (ignored when empty)
//   dout     : head word, valid while empty=0
//   empty    : no words held
//   count    : number of words held
module sgd_rd_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  assign w_pop = pop & (r_count != '0);

  // Storage and pointers; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/sgd_x_updated_rd_out.sv
// Read-out engine for the x_updated model BRAM. On start it sweeps addresses
// 0 .. ceil(dimension/LANES)-1 and streams each bank word to the writeback
// path over valid/ready.
//   clk, rst           : clock, asynchronous active-high reset
//   start, dimension   : sweep request and feature count (sampled at start)
//   busy, done         : sweep in progress / one-cycle completion pulse
//   x_updated_rd_addr  : BRAM read address
//   x_updated_rd_data  : BRAM read data, RD_LATENCY cycles after the address
//   out_data/valid/ready : writeback stream
module sgd_x_updated_rd_out
  import sgd_x_updated_rd_out_pkg::*;
#(
  parameter int unsigned LANES      = NUM_BITS_PER_BANK,
  parameter int unsigned LANE_BITS  = BIT_WIDTH_OF_BANK,
  parameter int unsigned ADDR_BITS  = X_BIT_DEPTH,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [31:0]            dimension,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_BITS-1:0]   x_updated_rd_addr,
  input  logic [LANES*32-1:0]    x_updated_rd_data,
  output logic [LANES*32-1:0]    out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned DATA_W = LANES * 32;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  rd_out_state_t        r_state;
  rd_out_state_t        w_state_nxt;
  logic [31:0]          r_total;
  logic [31:0]          r_issued;
  logic [31:0]          r_accepted;
  logic [31:0]          w_total;
  logic [ADDR_BITS-1:0] r_addr;
  logic [RD_LATENCY-1:0] r_tag;
  logic                 r_busy;
  logic                 r_done;
  logic [CNT_W-1:0]     w_fifo_count;
  logic [CNT_W-1:0]     w_inflight;
  logic                 w_fifo_empty;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;

  // Bank words needed: ceil(dimension / LANES).
  assign w_total = 32'(dimension[31:LANE_BITS]) + 32'(dimension[LANE_BITS-1:0] != '0);

  // Reads still travelling through the BRAM pipeline.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + CNT_W'(r_tag[i]);
    end
  end

  // Credit rule: every outstanding read already owns a FIFO slot.
  assign w_issue = (r_state == S_READ) && (r_issued < r_total) &&
                   ((32'(w_inflight) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH));
  assign w_push  = r_tag[RD_LATENCY-1];
  assign w_pop   = ~w_fifo_empty & out_ready;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_READ;
      S_READ:  if (r_issued == r_total) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_accepted == r_total) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Counters, address, return-tag pipeline and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_total    <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_addr     <= '0;
      r_tag      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_READ) || (w_state_nxt == S_DRAIN);
      r_done <= (w_state_nxt == S_DONE);
      // Shift in this cycle's issue; the oldest tag marks returning data.
      r_tag  <= RD_LATENCY'({r_tag, w_issue});
      if (r_state == S_IDLE) begin
        r_addr <= '0;
        if (start) begin
          r_total    <= w_total;
          r_issued   <= '0;
          r_accepted <= '0;
        end
      end else begin
        if (w_issue) begin
          r_addr   <= r_addr + ADDR_BITS'(1);
          r_issued <= r_issued + 32'd1;
        end
        if (w_pop) r_accepted <= r_accepted + 32'd1;
      end
    end
  end

  sgd_rd_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (x_updated_rd_data),
    .dout  (out_data),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign out_valid         = ~w_fifo_empty;
  assign busy              = r_busy;
  assign done              = r_done;
  assign x_updated_rd_addr = r_addr;

endmodule

// File: tb/tb_sgd_x_updated_rd_out.sv
// Self-checking bench for sgd_x_updated_rd_out with a 2-cycle BRAM model.
module tb_sgd_x_updated_rd_out;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = LANES * 32;
  localparam int unsigned AW    = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   dimension;
  logic          busy;
  logic          done;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  always #5 clk = ~clk;

  sgd_x_updated_rd_out dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .dimension         (dimension),
    .busy              (busy),
    .done              (done),
    .x_updated_rd_addr (rd_addr),
    .x_updated_rd_data (rd_data),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready)
  );

  // BRAM model: two register stages from address to data.
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] p1;
  always @(posedge clk) begin
    p1      <= mem[rd_addr];
    rd_data <= p1;
  end

  int checks = 0;
  int failures = 0;

  // Observations of one sweep.
  logic [DW-1:0] got[$];
  int acc_cyc[$];
  int done_cyc[$];
  int first_valid;
  int busy_cycles;
  int max_count;
  int unstable;
  int timed_out;
  int busy_at_done;
  int busy_before_done;
  int valid_seen;

  task automatic fill_random();
    for (int k = 0; k < 128; k++)
      for (int l = 0; l < LANES; l++)
        mem[k][l*32 +: 32] = $urandom();
  endtask

  // mode 0: ready always; 1: ready 1-of-3 with a 20-cycle stall; 2: random ready.
  task automatic do_sweep(input int dim, input int mode, input int second_start_at,
                          input int reset_at, input int max_cyc);
    logic pv;
    logic [DW-1:0] pd;
    int cyc;
    int post_done;
    int prev_busy;
    got.delete(); acc_cyc.delete(); done_cyc.delete();
    first_valid = -1; busy_cycles = 0; max_count = 0; unstable = 0; timed_out = 0;
    busy_at_done = -1; busy_before_done = -1; valid_seen = 0;
    @(negedge clk);
    dimension = 32'(dim);
    start = 1'b1;
    out_ready = 1'b0;
    cyc = 0; pv = 1'b0; pd = '0; post_done = -1; prev_busy = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = (cyc == second_start_at);
      if (start) dimension = 32'd64;
      if (busy) busy_cycles++;
      if (done) begin
        done_cyc.push_back(cyc);
        busy_at_done = int'(busy);
        busy_before_done = prev_busy;
      end
      prev_busy = int'(busy);
      if (out_valid) valid_seen++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (int'(dut.u_fifo.count) > max_count) max_count = int'(dut.u_fifo.count);
      if (pv && !(out_valid && out_data == pd)) unstable++;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc % 3 == 0) && !(cyc >= 10 && cyc < 30);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      pv = out_valid && !out_ready;
      pd = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        acc_cyc.push_back(cyc);
      end
      if (reset_at > 0 && got.size() == reset_at) break;
      if (done && post_done < 0) post_done = cyc;
      if (post_done >= 0 && cyc >= post_done + 3) break;
      if (cyc >= max_cyc) begin timed_out = 1; break; end
    end
    if (reset_at == 0) out_ready = 1'b0;
  endtask

  // Compare captured words against mem[0 .. ceil(dim/LANES)-1].
  task automatic check_words(input string name, input int dim);
    int total;
    total = (dim + LANES - 1) / LANES;
    checks++;
    if (timed_out !== 0) begin
      failures++;
      $display("FAIL %s timeout: no done within cycle budget", name);
    end
    checks++;
    if (got.size() !== total) begin
      failures++;
      $display("FAIL %s word_count: got %0d expected %0d", name, got.size(), total);
    end
    for (int k = 0; k < total && k < got.size(); k++) begin
      checks++;
      if (got[k] !== mem[k]) begin
        failures++;
        $display("FAIL %s word[%0d]: got %h expected %h", name, k, got[k], mem[k]);
      end
    end
    checks++;
    if (done_cyc.size() !== 1) begin
      failures++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cyc.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dimension = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b done=%b valid=%b expected 0 0 0", busy, done, out_valid);
    end
    checks++;
    if (rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr: got %0d expected 0", rd_addr);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    for (int k = 0; k < 128; k++) mem[k] = {LANES{32'(k)}};
    do_sweep(64, 0, -1, 0, 200);
    check_words("full", 64);
    checks++;
    if (first_valid !== 4) begin
      failures++;
      $display("FAIL full_first_valid: got %0d expected 4", first_valid);
    end
    for (int i = 0; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] !== 4 + i) begin
        failures++;
        $display("FAIL full_accept_cycle[%0d]: got %0d expected %0d", i, acc_cyc[i], 4 + i);
      end
    end
    if (done_cyc.size() > 0 && acc_cyc.size() > 0) begin
      checks++;
      if (done_cyc[0] !== acc_cyc[acc_cyc.size()-1] + 2) begin
        failures++;
        $display("FAIL full_done_cycle: got %0d expected %0d", done_cyc[0],
                 acc_cyc[acc_cyc.size()-1] + 2);
      end
    end
    checks++;
    if (rd_addr !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL full_idle_after: addr=%0d busy=%b expected 0 0", rd_addr, busy);
    end
  endtask

  task automatic test_partial();
    fill_random();
    do_sweep(20, 0, -1, 0, 200);
    check_words("partial", 20);
    checks++;
    if (busy_at_done !== 0 || busy_before_done !== 1) begin
      failures++;
      $display("FAIL partial_busy_drop: at_done=%0d before=%0d expected 0 1",
               busy_at_done, busy_before_done);
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    do_sweep(64, 1, -1, 0, 400);
    check_words("backpressure", 64);
    checks++;
    if (unstable !== 0) begin
      failures++;
      $display("FAIL backpressure_stable: got %0d changes expected 0", unstable);
    end
    checks++;
    if (max_count > 4) begin
      failures++;
      $display("FAIL backpressure_fifo_count: got %0d expected <= 4", max_count);
    end
  endtask

  task automatic test_zero_dim();
    do_sweep(0, 0, -1, 0, 50);
    checks++;
    if (valid_seen !== 0) begin
      failures++;
      $display("FAIL zero_valid: got %0d valid cycles expected 0", valid_seen);
    end
    checks++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== 3) begin
      failures++;
      $display("FAIL zero_done: got %0d pulses first at %0d expected 1 at 3",
               done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    checks++;
    if (busy_cycles !== 2) begin
      failures++;
      $display("FAIL zero_busy_cycles: got %0d expected 2", busy_cycles);
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    do_sweep(16, 0, 2, 0, 200);
    check_words("double_start", 16);
    do_sweep(24, 0, -1, 0, 200);
    check_words("restart", 24);
    checks++;
    if (first_valid !== 4) begin
      failures++;
      $display("FAIL restart_first_valid: got %0d expected 4", first_valid);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    fill_random();
    do_sweep(64, 0, -1, 3, 200);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || rd_addr !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL midreset_async: busy=%b done=%b valid=%b addr=%0d data=%h expected all 0",
               busy, done, out_valid, rd_addr, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d active cycles expected 0", bad);
    end
    do_sweep(16, 0, -1, 0, 200);
    check_words("after_reset", 16);
  endtask

  task automatic test_random();
    int dim;
    for (int r = 0; r < 4; r++) begin
      fill_random();
      dim = $urandom_range(1, 120);
      do_sweep(dim, 2, -1, 0, 2000);
      check_words("random", dim);
      checks++;
      if (max_count > 4) begin
        failures++;
        $display("FAIL random_fifo_count: got %0d expected <= 4", max_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_sweep();
    test_partial();
    test_backpressure();
    test_zero_dim();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
